uart_mem_loader: RTL and testbench
==================================

# uart_mem_loader

Serial boot loader that receives a program image over a UART line and writes it, one 32-bit word per strobe, into instruction or data memory through the same word-addressed write port the core uses. It sits beside the core in the FPGA top. While a load is in progress it holds the core in reset through `busy`, so a new image can be pushed without re-synthesising the memory initialisation files.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: core clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- `ADDR_W`, default 16: word-address width, matching the `a[17:2]` memory port.
- `DATA_W`, default 32: memory word width; fixed at 32 (4 bytes per word).

Ports (single clock domain):
- `clk`  in  1: core clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rxd`  in  1: UART receive line, 8N1, idle high, asynchronous to `clk`.
- `we`  out  1: one-cycle memory write strobe.
- `waddr`  out  ADDR_W: word address for `we`.
- `wdata`  out  DATA_W: word data for `we`.
- `busy`  out  1: load in progress; the top ORs it into core reset.
- `done`  out  1: image fully written; sticky.
- `err`  out  1: framing error seen; sticky.

## Operation

- `rxd` passes through a 2-flop synchroniser. All decoding uses the synchronised line.
- The bit receiver has states R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE → R_START on a synchronised falling edge.
  - In R_START, the line is sampled at CLKS_PER_BIT/2. If it reads 1 (glitch), return to R_IDLE. If 0, go to R_DATA.
  - R_DATA takes 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - R_STOP samples once. A 1 produces an internal `byte_valid` pulse with the byte. A 0 produces a `frame_err` pulse. Either way, return to R_IDLE.
- The packet parser has states P_SYNC, P_LEN_HI, P_LEN_LO, P_DATA.
  - P_SYNC: bytes other than 0xA5 are ignored. On 0xA5: clear `done` and `err`, set `busy`, go to P_LEN_HI.
  - P_LEN_HI / P_LEN_LO: capture the big-endian 16-bit word count N. If N = 0, finish immediately (see below). Otherwise clear the word index and byte lane, and go to P_DATA.
  - P_DATA: each word arrives as 4 bytes, little-endian (first byte → `wdata[7:0]`). After the 4th byte, pulse `we` with `waddr` = word index (mod 2^ADDR_W), then increment the index. After the Nth word, finish.
  - Finish means: `busy` 0, `done` 1, go to P_SYNC.
- A `frame_err` in any state other than P_SYNC sets `err`, clears `busy`, leaves `done` at 0, and returns the parser to P_SYNC. Words already written stay in memory.
- A `frame_err` in P_SYNC sets `err` only.
- A 0xA5 arriving while `done` = 1 starts a new load, clearing `done`.
- A 0xA5 inside P_LEN_* or P_DATA is treated as data, not as a resync.

## Timing

- Reset values: `we`, `waddr`, `wdata`, `busy`, `done`, `err` are all 0. Both FSMs reset to idle/P_SYNC.
- Asserting `rst_n` mid-frame aborts immediately; no partial write is issued.
- Synchroniser latency: 2 cycles.
- `byte_valid` fires at the mid-stop-bit sample.
- `we`, `waddr` and `wdata` are registered. They assert on the cycle after the `byte_valid` of a word's 4th byte, for exactly 1 cycle.
- `waddr` and `wdata` hold their values after `we` falls, until the next word.
- `busy` rises the cycle after the 0xA5 `byte_valid`.
- `busy` falls, and `done` rises, on the same edge that deasserts the final `we`.
- For N = 0, `busy` falls and `done` rises the cycle after the LEN_LO `byte_valid`.
- `err` rises the cycle after the bad stop-bit sample.
- Back-to-back bytes at full line rate (zero idle gap) must be accepted; the receiver re-arms in R_IDLE within the stop bit.

## Test plan

- **Single word.** CLKS_PER_BIT = 8; send A5 00 01 78 56 34 12 → one `we` pulse with `waddr` = 0, `wdata` = 0x12345678. Then `busy` 0, `done` 1, `err` 0.
- **Three words, back-to-back.** Send A5 00 03 followed by words 0x11111111, 0xDEADBEEF, 0x00000000, no gaps → `we` at addresses 0, 1, 2 with matching data. `busy` is high from the cycle after A5 until the edge that ends the third `we`.
- **Noise and zero length.** Send junk bytes 00 FF 3C, then A5 00 00 → no `we`; `done` rises the cycle after the 2nd length byte.
- **Framing error.** During a 2-word load, force the stop bit of byte 6 low → exactly one `we` (addr 0), `err` 1, `busy` 0, `done` 0. A following A5 00 01 … load clears `err` and completes.
- **Reset and glitch.** A 2-cycle low glitch on `rxd` → no byte decoded. Asserting `rst_n` low mid-word → all outputs 0 immediately. A full image sent after release loads correctly.
- **Address wrap.** With ADDR_W = 2 and N = 5 → `waddr` sequence 0, 1, 2, 3, 0.

Source files
------------

// File: rtl/uart_mem_loader.sv
// ============================================================================
// uart_mem_loader
//
// Serial boot loader. It receives a program image over an 8N1 UART line and
// writes it into instruction or data memory, one 32-bit word per strobe.
// It uses the same word-addressed write port that the core uses. While a load
// is in progress, `busy` is high and the FPGA top holds the core in reset
// with it.
//
// Image format on the wire:
//   0xA5, LEN_HI, LEN_LO, then LEN words of 4 bytes each, little-endian.
//
// Parameters:
//   CLKS_PER_BIT - core clock cycles per UART bit (>= 4)
//   ADDR_W       - word-address width of the memory write port
//   DATA_W       - memory word width (32, four bytes per word)
//
// Ports:
//   clk    - core clock
//   rst_n  - asynchronous active-low reset
//   rxd    - UART receive line, idle high, asynchronous to clk
//   we     - one-cycle memory write strobe
//   waddr  - word address for we (held until the next word)
//   wdata  - word data for we (held until the next word)
//   busy   - load in progress
//   done   - image fully written (sticky until the next 0xA5)
//   err    - framing error seen (sticky until the next 0xA5)
// ============================================================================
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts for the bit timer. Half-bit centres the start-bit
    // sample. Every later sample is then one full bit after the previous one.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_SYNC,
        P_LEN_HI,
        P_LEN_LO,
        P_DATA
    } p_state_t;

    // Line synchroniser and edge-detect history
    logic rxd_meta;
    logic rxd_sync;
    logic rxd_prev;

    // Bit receiver
    rx_state_t        rx_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             frame_err;

    // Packet parser
    p_state_t          p_state;
    logic [7:0]        len_hi;
    logic [15:0]       word_len;
    logic [15:0]       word_cnt;
    logic [ADDR_W-1:0] addr_idx;
    logic [1:0]        lane;
    logic [23:0]       word_buf;
    logic              fin_pending;

    // The raw line comes from outside the clock domain. It passes through
    // two flops before anything looks at it. A third flop keeps the previous
    // synchronised value so the idle state can spot a falling edge. All three
    // reset to the idle-high level so that reset itself cannot look like a
    // start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Bit receiver. A falling edge arms the start check. A line that is
    // high again at mid-start is treated as a glitch and ignored. Data bits
    // arrive LSB first and shift in from the top, so the first bit ends in
    // bit 0. The stop bit is sampled mid-bit and the state returns to idle
    // straight away. This leaves half a bit to catch the next start edge
    // when bytes arrive back to back. byte_valid and frame_err are
    // single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= R_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    bit_cnt <= '0;
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        rx_state <= rxd_sync ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        rx_byte <= {rxd_sync, rx_byte[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= R_IDLE;
                        if (rxd_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Packet parser, which also drives all memory-side outputs.
    //
    // A word is assembled little-endian. The first three bytes are kept in
    // word_buf, and the fourth byte completes wdata and fires we for one
    // cycle. The write address is a separate ADDR_W-bit counter, so it wraps
    // naturally. The 16-bit word_cnt tracks progress against the length
    // field.
    //
    // On the last word, the parser returns to P_SYNC at once. busy/done are
    // updated one cycle later, through fin_pending, so that they change on
    // the same edge that drops we.
    //
    // A framing error during a load abandons it: err is set, busy is
    // cleared, and done stays 0. Words already written are not undone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state     <= P_SYNC;
            len_hi      <= '0;
            word_len    <= '0;
            word_cnt    <= '0;
            addr_idx    <= '0;
            lane        <= '0;
            word_buf    <= '0;
            fin_pending <= 1'b0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            we <= 1'b0;

            if (fin_pending) begin
                fin_pending <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
            end

            if (frame_err) begin
                err <= 1'b1;
                if (p_state != P_SYNC) begin
                    busy    <= 1'b0;
                    p_state <= P_SYNC;
                end
            end else if (byte_valid) begin
                case (p_state)
                    P_SYNC: begin
                        if (rx_byte == SYNC_BYTE) begin
                            done    <= 1'b0;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            p_state <= P_LEN_HI;
                        end
                    end
                    P_LEN_HI: begin
                        len_hi  <= rx_byte;
                        p_state <= P_LEN_LO;
                    end
                    P_LEN_LO: begin
                        if ({len_hi, rx_byte} == 16'd0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            p_state <= P_SYNC;
                        end else begin
                            word_len <= {len_hi, rx_byte};
                            word_cnt <= '0;
                            addr_idx <= '0;
                            lane     <= '0;
                            p_state  <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        lane <= lane + 1'b1;
                        case (lane)
                            2'd0: word_buf[7:0]   <= rx_byte;
                            2'd1: word_buf[15:8]  <= rx_byte;
                            2'd2: word_buf[23:16] <= rx_byte;
                            default: begin
                                we       <= 1'b1;
                                waddr    <= addr_idx;
                                wdata    <= {rx_byte, word_buf};
                                addr_idx <= addr_idx + 1'b1;
                                word_cnt <= word_cnt + 1'b1;
                                if (word_cnt == 16'(word_len - 16'd1)) begin
                                    fin_pending <= 1'b1;
                                    p_state     <= P_SYNC;
                                end
                            end
                        endcase
                    end
                    default: p_state <= P_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// ============================================================================
// tb_uart_mem_loader
//
// Directed bench for uart_mem_loader. It runs two instances that share the
// same UART line and reset: one with a 16-bit word address, and one with a
// 2-bit word address used for the address-wrap case. Bytes are driven
// bit-serially at CLKS_PER_BIT = 8. A negedge monitor records every write
// strobe, together with the busy/done levels seen just after it.
// ============================================================================
module tb_uart_mem_loader;

    localparam int CLKS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;

    logic        we;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    logic        w_we;
    logic [1:0]  w_waddr;
    logic [31:0] w_wdata;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    int tests_run = 0;
    int tests_failed = 0;

    int unsigned we_addr_q[$];
    int unsigned we_data_q[$];
    int unsigned busy_at_we_q[$];
    int unsigned post_busy_q[$];
    int unsigned post_done_q[$];
    int unsigned w_addr_q[$];
    logic [7:0]  img[$];
    logic        prev_we = 1'b0;

    uart_mem_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(16), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    uart_mem_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(2), .DATA_W(32)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .busy  (w_busy),
        .done  (w_done),
        .err   (w_err)
    );

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    // Capture write strobes away from the active edge. The busy/done levels
    // one cycle after we falls show whether the finish happened on the edge
    // that ended the strobe.
    always @(negedge clk) begin
        if (we) begin
            we_addr_q.push_back(32'(waddr));
            we_data_q.push_back(wdata);
            busy_at_we_q.push_back(32'(busy));
        end
        if (prev_we && !we) begin
            post_busy_q.push_back(32'(busy));
            post_done_q.push_back(32'(done));
        end
        prev_we = we;
        if (w_we) begin
            w_addr_q.push_back(32'(w_waddr));
        end
    end

    function automatic logic [31:0] q_at(input int unsigned q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send one 8N1 frame, LSB first, starting at the current negedge.
    // stop_bit = 0 forces a framing error. The line is left idle-high.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        idleCycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idleCycles(CLKS);
        end
        rxd = stop_bit;
        idleCycles(CLKS);
        rxd = 1'b1;
    endtask

    task automatic sendImage();
        foreach (img[i]) applyStimulus(img[i], 1'b1);
    endtask

    task automatic clearCapture();
        we_addr_q.delete();
        we_data_q.delete();
        busy_at_we_q.delete();
        post_busy_q.delete();
        post_done_q.delete();
        w_addr_q.delete();
    endtask

    initial begin
        // ---------------- reset state ----------------
        idleCycles(3);
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_waddr", 32'(waddr), 0);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        idleCycles(5);

        // ---------------- single word ----------------
        clearCapture();
        applyStimulus(8'hA5, 1'b1);
        checkOutput("t1_busy_after_sync", 32'(busy), 1);
        img = '{8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        sendImage();
        idleCycles(4);
        checkOutput("t1_we_count", we_addr_q.size(), 1);
        checkOutput("t1_addr", q_at(we_addr_q, 0), 0);
        checkOutput("t1_data", q_at(we_data_q, 0), 32'h1234_5678);
        checkOutput("t1_post_busy", q_at(post_busy_q, 0), 0);
        checkOutput("t1_post_done", q_at(post_done_q, 0), 1);
        checkOutput("t1_busy", 32'(busy), 0);
        checkOutput("t1_done", 32'(done), 1);
        checkOutput("t1_err", 32'(err), 0);

        // ---------------- three words back to back ----------------
        clearCapture();
        img = '{8'hA5, 8'h00, 8'h03,
                8'h11, 8'h11, 8'h11, 8'h11,
                8'hEF, 8'hBE, 8'hAD, 8'hDE,
                8'h00, 8'h00, 8'h00, 8'h00};
        sendImage();
        idleCycles(4);
        checkOutput("t2_we_count", we_addr_q.size(), 3);
        checkOutput("t2_addr0", q_at(we_addr_q, 0), 0);
        checkOutput("t2_addr1", q_at(we_addr_q, 1), 1);
        checkOutput("t2_addr2", q_at(we_addr_q, 2), 2);
        checkOutput("t2_data0", q_at(we_data_q, 0), 32'h1111_1111);
        checkOutput("t2_data1", q_at(we_data_q, 1), 32'hDEAD_BEEF);
        checkOutput("t2_data2", q_at(we_data_q, 2), 32'h0000_0000);
        checkOutput("t2_busy_we0", q_at(busy_at_we_q, 0), 1);
        checkOutput("t2_busy_we2", q_at(busy_at_we_q, 2), 1);
        checkOutput("t2_post_busy1", q_at(post_busy_q, 1), 1);
        checkOutput("t2_post_busy2", q_at(post_busy_q, 2), 0);
        checkOutput("t2_post_done1", q_at(post_done_q, 1), 0);
        checkOutput("t2_post_done2", q_at(post_done_q, 2), 1);
        checkOutput("t2_waddr_hold", 32'(waddr), 2);

        // ---------------- noise then zero length ----------------
        clearCapture();
        img = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00};
        sendImage();
        checkOutput("t3_done_cleared", 32'(done), 0);
        checkOutput("t3_busy_mid", 32'(busy), 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t3_done", 32'(done), 1);
        checkOutput("t3_busy", 32'(busy), 0);
        checkOutput("t3_we_count", we_addr_q.size(), 0);

        // ---------------- framing error mid-load ----------------
        clearCapture();
        img = '{8'hA5, 8'h00, 8'h02, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        sendImage();
        applyStimulus(8'h44, 1'b1);
        applyStimulus(8'h33, 1'b0);
        idleCycles(12);
        checkOutput("t4_we_count", we_addr_q.size(), 1);
        checkOutput("t4_addr", q_at(we_addr_q, 0), 0);
        checkOutput("t4_data", q_at(we_data_q, 0), 32'hCAFE_F00D);
        checkOutput("t4_err", 32'(err), 1);
        checkOutput("t4_busy", 32'(busy), 0);
        checkOutput("t4_done", 32'(done), 0);
        clearCapture();
        applyStimulus(8'hA5, 1'b1);
        checkOutput("t4_err_cleared", 32'(err), 0);
        img = '{8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sendImage();
        idleCycles(4);
        checkOutput("t4_rec_count", we_addr_q.size(), 1);
        checkOutput("t4_rec_data", q_at(we_data_q, 0), 32'hDEAD_BEEF);
        checkOutput("t4_rec_done", 32'(done), 1);

        // ---------------- glitch inside the length field ----------------
        clearCapture();
        applyStimulus(8'hA5, 1'b1);
        rxd = 1'b0;
        idleCycles(2);
        rxd = 1'b1;
        idleCycles(40);
        img = '{8'h00, 8'h01, 8'hDF, 8'h9B, 8'h57, 8'h13};
        sendImage();
        idleCycles(4);
        checkOutput("t5_glitch_count", we_addr_q.size(), 1);
        checkOutput("t5_glitch_data", q_at(we_data_q, 0), 32'h1357_9BDF);
        checkOutput("t5_glitch_done", 32'(done), 1);

        // ---------------- reset mid-word ----------------
        clearCapture();
        img = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};
        sendImage();
        rxd = 1'b0;
        idleCycles(CLKS);
        rxd = 1'b1;
        idleCycles(2 * CLKS);
        checkOutput("t5_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_we", 32'(we), 0);
        checkOutput("t5_rst_waddr", 32'(waddr), 0);
        checkOutput("t5_rst_wdata", wdata, 0);
        checkOutput("t5_rst_busy", 32'(busy), 0);
        checkOutput("t5_rst_done", 32'(done), 0);
        checkOutput("t5_rst_err", 32'(err), 0);
        rxd = 1'b1;
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(20);
        clearCapture();
        img = '{8'hA5, 8'h00, 8'h02,
                8'hA5, 8'hA5, 8'hA5, 8'hA5,
                8'h04, 8'h03, 8'h02, 8'h01};
        sendImage();
        idleCycles(4);
        checkOutput("t5_post_count", we_addr_q.size(), 2);
        checkOutput("t5_post_addr1", q_at(we_addr_q, 1), 1);
        checkOutput("t5_post_data0", q_at(we_data_q, 0), 32'hA5A5_A5A5);
        checkOutput("t5_post_data1", q_at(we_data_q, 1), 32'h0102_0304);
        checkOutput("t5_post_done", 32'(done), 1);
        checkOutput("t5_post_busy", 32'(busy), 0);

        // ---------------- address wrap on the 2-bit instance ----------------
        clearCapture();
        img = '{8'hA5, 8'h00, 8'h05};
        for (int k = 1; k <= 5; k++) begin
            img.push_back(8'(k));
            img.push_back(8'h00);
            img.push_back(8'h00);
            img.push_back(8'h00);
        end
        sendImage();
        idleCycles(4);
        checkOutput("t6_main_count", we_addr_q.size(), 5);
        checkOutput("t6_main_addr4", q_at(we_addr_q, 4), 4);
        checkOutput("t6_main_data4", q_at(we_data_q, 4), 32'h0000_0005);
        checkOutput("t6_wrap_count", w_addr_q.size(), 5);
        checkOutput("t6_wrap_addr2", q_at(w_addr_q, 2), 2);
        checkOutput("t6_wrap_addr3", q_at(w_addr_q, 3), 3);
        checkOutput("t6_wrap_addr4", q_at(w_addr_q, 4), 0);
        checkOutput("t6_wrap_data", w_wdata, 32'h0000_0005);
        checkOutput("t6_wrap_done", 32'(w_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
